// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the data-RAM arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default RAM word-address and data widths
//   PORT_M0 / PORT_M1       : requester ids used for read-return routing
//   pri_state_e             : arbitration priority state (PRI_M0 / PRI_M1)
package dmem_pkg;

    localparam int unsigned DEF_ADDR_W = 14;
    localparam int unsigned DEF_DATA_W = 32;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

    typedef enum logic {
        PRI_M0 = 1'b0,
        PRI_M1 = 1'b1
    } pri_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port of the data-RAM arbiter.
//   req/we/addr/wdata : request and attributes, held by the master until gnt
//   gnt               : request accepted this cycle
//   rvalid/rdata      : read data, one cycle after a granted read
// master modport is the requester side, slave modport is the arbiter side.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr: anti-starvation tracker for port 1.
//   clock, reset : system clock, async active-high reset
//   m1_req       : port 1 is requesting
//   m1_gnt       : port 1 was granted this cycle
//   m1_priority  : port 1 currently has priority over port 0
// Counts consecutive ungranted port-1 request cycles (saturating at MAX_WAIT);
// reaching MAX_WAIT hands priority to port 1 until it is served or gives up.
module dmem_starve_ctr
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic m1_req,
    input  logic m1_gnt,
    output logic m1_priority
);

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    pri_state_e state_q, state_d;
    logic [7:0] wait_q, wait_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= PRI_M0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        wait_d  = wait_q;
        state_d = state_q;

        if (!m1_req || m1_gnt) begin
            wait_d = '0;
        end else if (wait_q < MaxWait) begin
            wait_d = wait_q + 8'd1;
        end

        // Promote on the edge where the count arrives at MAX_WAIT so port 1
        // wins in the very next cycle.
        case (state_q)
            PRI_M0:  if (wait_d == MaxWait) state_d = PRI_M1;
            PRI_M1:  if (m1_gnt || !m1_req) state_d = PRI_M0;
            default: state_d = PRI_M0;
        endcase
    end

    assign m1_priority = (state_q == PRI_M1);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of the single-port data RAM.
//   clock, reset      : system clock, async active-high reset
//   m0 (slave)        : CPU data port, fixed priority
//   m1 (slave)        : DMA/loader port, promoted after MAX_WAIT ungranted cycles
//   ram_we/addr/din   : RAM drive from the granted port (zero when idle)
//   ram_dout          : RAM read data, valid the cycle after the address
// Grants are combinational; read data is routed back one cycle later to the
// port that owned the read.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic m1_priority;
    logic gnt0, gnt1;
    logic rd_valid_q, rd_valid_d;
    logic rd_owner_q, rd_owner_d;

    dmem_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clock       (clock),
        .reset       (reset),
        .m1_req      (m1.req),
        .m1_gnt      (gnt1),
        .m1_priority (m1_priority)
    );

    // Grants are held low during reset regardless of requests.
    assign gnt1 = !reset && m1.req && (m1_priority || !m0.req);
    assign gnt0 = !reset && m0.req && !gnt1;

    assign m0.gnt = gnt0;
    assign m1.gnt = gnt1;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (gnt0) begin
            ram_we   = m0.we;
            ram_addr = m0.addr[ADDR_W+1:2];
            ram_din  = m0.wdata;
        end else if (gnt1) begin
            ram_we   = m1.we;
            ram_addr = m1.addr[ADDR_W+1:2];
            ram_din  = m1.wdata;
        end
    end

    // Byte-lane and out-of-range address bits are intentionally ignored.
    logic unused_addr;
    assign unused_addr = ^{m0.addr[1:0], m0.addr[31:ADDR_W+2],
                           m1.addr[1:0], m1.addr[31:ADDR_W+2]};

    always_comb begin
        rd_valid_d = (gnt0 && !m0.we) || (gnt1 && !m1.we);
        rd_owner_d = gnt1 ? PORT_M1 : PORT_M0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_owner_q <= PORT_M0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    assign m0.rvalid = rd_valid_q && (rd_owner_q == PORT_M0);
    assign m1.rvalid = rd_valid_q && (rd_owner_q == PORT_M1);
    assign m0.rdata  = m0.rvalid ? ram_dout : '0;
    assign m1.rdata  = m1.rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. A behavioural RAM
// sits on the RAM side; a reference model tracks port-1 waiting time, the
// expected memory contents and the outstanding read.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int unsigned ADDR_W   = 14;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_WAIT = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    dmem_arbiter_if #(.DATA_W(DATA_W)) p0 ();
    dmem_arbiter_if #(.DATA_W(DATA_W)) p1 ();

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .m0       (p0),
        .m1       (p1),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clock = ~clock;

    // Single-port synchronous RAM.
    logic [DATA_W-1:0] ram_mem [2**ADDR_W];
    always @(posedge clock) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // Reference model state.
    logic [31:0]  shadow [int];
    int unsigned  mdl_wait = 0;
    bit           mdl_g0 = 0, mdl_g1 = 0;
    bit           pend_v = 0, pend_port = 0, pend_known = 0;
    logic [31:0]  pend_data = 0;
    bit           obs_g1 = 0;
    int           n_tests = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        p0.req = req; p0.we = we; p0.addr = addr; p0.wdata = wdata;
    endtask

    task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        p1.req = req; p1.we = we; p1.addr = addr; p1.wdata = wdata;
    endtask

    // Called just after a falling edge with inputs set; checks this cycle and
    // advances the model across the next rising edge.
    task automatic cycle();
        bit          e_g0, e_g1, e_we, r0, r1;
        logic [31:0] e_addr, e_din;
        int          widx;
        #2;
        e_g1 = p1.req && (!p0.req || mdl_wait >= MAX_WAIT);
        e_g0 = p0.req && !e_g1;
        e_we = 0; e_addr = 0; e_din = 0;
        if (e_g0) begin
            e_we = p0.we; e_addr = (p0.addr >> 2) % (2**ADDR_W); e_din = p0.wdata;
        end else if (e_g1) begin
            e_we = p1.we; e_addr = (p1.addr >> 2) % (2**ADDR_W); e_din = p1.wdata;
        end
        check_eq("m0_gnt", 32'(p0.gnt), 32'(e_g0));
        check_eq("m1_gnt", 32'(p1.gnt), 32'(e_g1));
        check_eq("ram_we", 32'(ram_we), 32'(e_we));
        check_eq("ram_addr", 32'(ram_addr), e_addr);
        check_eq("ram_din", ram_din, e_din);
        r0 = pend_v && pend_port == PORT_M0;
        r1 = pend_v && pend_port == PORT_M1;
        check_eq("m0_rvalid", 32'(p0.rvalid), 32'(r0));
        check_eq("m1_rvalid", 32'(p1.rvalid), 32'(r1));
        if (!r0) check_eq("m0_rdata_idle", p0.rdata, 32'h0);
        else if (pend_known) check_eq("m0_rdata", p0.rdata, pend_data);
        if (!r1) check_eq("m1_rdata_idle", p1.rdata, 32'h0);
        else if (pend_known) check_eq("m1_rdata", p1.rdata, pend_data);
        obs_g1 = p1.gnt;

        pend_v = 0;
        if (e_g0 || e_g1) begin
            widx = int'(e_addr);
            if (e_we) begin
                shadow[widx] = e_din;
            end else begin
                pend_v     = 1;
                pend_port  = e_g1 ? PORT_M1 : PORT_M0;
                pend_known = shadow.exists(widx);
                pend_data  = pend_known ? shadow[widx] : 32'h0;
            end
        end
        if (p1.req && !e_g1) mdl_wait = (mdl_wait < MAX_WAIT) ? mdl_wait + 1 : mdl_wait;
        else mdl_wait = 0;
        mdl_g0 = e_g0;
        mdl_g1 = e_g1;
        @(negedge clock);
    endtask

    // Reset with both ports requesting writes: everything must read as idle.
    task automatic do_reset();
        reset = 1'b1;
        set_m0(1, 1, 32'h10, 32'hFFFF_FFFF);
        set_m1(1, 1, 32'h20, 32'hFFFF_FFFF);
        #2;
        check_eq("rst_m0_gnt", 32'(p0.gnt), 32'h0);
        check_eq("rst_m1_gnt", 32'(p1.gnt), 32'h0);
        check_eq("rst_ram_we", 32'(ram_we), 32'h0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'h0);
        check_eq("rst_ram_din", ram_din, 32'h0);
        check_eq("rst_m0_rvalid", 32'(p0.rvalid), 32'h0);
        check_eq("rst_m1_rvalid", 32'(p1.rvalid), 32'h0);
        check_eq("rst_m0_rdata", p0.rdata, 32'h0);
        check_eq("rst_m1_rdata", p1.rdata, 32'h0);
        @(negedge clock);
        @(negedge clock);
        set_m0(0, 0, 0, 0);
        set_m1(0, 0, 0, 0);
        reset = 1'b0;
        pend_v = 0; mdl_wait = 0; mdl_g0 = 0; mdl_g1 = 0;
    endtask

    function automatic logic [31:0] rnd_addr();
        return ($urandom() & 32'hFFFF_0003) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        set_m0(0, 0, 0, 0);
        set_m1(0, 0, 0, 0);
        do_reset();

        // m0 write then read back through the same address.
        set_m0(1, 1, 32'h10, 32'hDEAD_BEEF); cycle();
        set_m0(1, 0, 32'h10, 32'h0);         cycle();
        set_m0(0, 0, 0, 0);                  cycle();

        // Simultaneous writes, then simultaneous reads held one cycle.
        set_m0(1, 1, 32'h40, 32'hA0A0_0040); set_m1(1, 1, 32'h80, 32'hB1B1_0080); cycle();
        set_m0(0, 0, 0, 0);                  cycle();
        set_m0(1, 0, 32'h40, 0); set_m1(1, 0, 32'h80, 0); cycle();
        set_m0(0, 0, 0, 0);                  cycle();
        set_m1(0, 0, 0, 0);                  cycle();

        // Port 1 starved by continuous port 0 traffic.
        waited = 0;
        set_m1(1, 0, 32'h80, 0);
        for (int k = 0; k < 20; k++) begin
            set_m0(1, 0, 32'h40 + 32'(k % 4) * 4, 0);
            cycle();
            if (obs_g1) break;
            waited++;
        end
        check_eq("starve_wait", 32'(waited), 32'(MAX_WAIT));
        set_m1(0, 0, 0, 0); cycle();
        set_m1(1, 0, 32'h80, 0); cycle();    // priority back with port 0
        set_m0(0, 0, 0, 0); cycle();
        set_m1(0, 0, 0, 0); cycle();

        // Alternating reads with distinct data on each address.
        set_m0(1, 1, 32'h100, 32'h1111_0100); cycle();
        set_m0(1, 1, 32'h204, 32'h2222_0204); cycle();
        set_m0(1, 1, 32'h308, 32'h3333_0308); cycle();
        set_m0(1, 0, 32'h100, 0); cycle();
        set_m0(0, 0, 0, 0); set_m1(1, 0, 32'h204, 0); cycle();
        set_m1(0, 0, 0, 0); set_m0(1, 0, 32'h308, 0); cycle();
        set_m0(0, 0, 0, 0); cycle();

        // Reset right after a granted m1 read drops the return.
        set_m1(1, 0, 32'h204, 0); cycle();
        set_m1(0, 0, 0, 0);
        do_reset();
        cycle();
        cycle();

        // Misaligned write, aligned read back.
        set_m1(1, 1, 32'h403, 32'h1234_5678); cycle();
        set_m1(0, 0, 0, 0); set_m0(1, 0, 32'h400, 0); cycle();
        set_m0(0, 0, 0, 0); cycle();

        // Randomised traffic honouring hold-until-grant, with occasional drops.
        for (int c = 0; c < 500; c++) begin
            if (!p0.req || mdl_g0 || $urandom_range(0, 19) == 0)
                set_m0($urandom_range(0, 99) < 75, 1'($urandom()), rnd_addr(), $urandom());
            if (!p1.req || mdl_g1 || $urandom_range(0, 29) == 0)
                set_m1($urandom_range(0, 99) < 55, 1'($urandom()), rnd_addr(), $urandom());
            cycle();
        end
        set_m0(0, 0, 0, 0);
        set_m1(0, 0, 0, 0);
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
